// File: rtl/rx_dec_loader.sv
// ---------------------------------------------------------------------------
// rx_dec_loader
//
// ASCII-decimal sample loader sitting between uart_rx and the filter datapath.
// Parses a byte stream of decimal tokens separated by delimiters (space, ',',
// CR, LF), saturates each value to DATA_W bits and stores it in an internal
// DEPTH-entry buffer that is read back through a registered address port.
//
// Optional feature: define RX_DEC_LOADER_SIGNED_EN to accept a leading '-'
// and store two's-complement values clamped to the signed DATA_W range.
// Without it, '-' is a bad character and all values are unsigned.
//
// Parameters
//   DATA_W  stored sample width
//   DEPTH   samples per load (>= 2)
//   AW      read address width, derived from DEPTH
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   data_in     received character
//   data_valid  one-cycle strobe qualifying data_in
//   start       synchronous re-arm pulse (wins over data_valid)
//   rd_addr     read address
//   rd_data     read data, one cycle after rd_addr
//   count       samples stored since reset/start
//   busy        a token is in progress (DIGIT or DISCARD)
//   done        DEPTH samples stored
//   err         sticky: a malformed token was dropped
//   sat         sticky: a stored value was clamped
//
// state   | meaning
// --------+------------------------------------------------------------
// SKIP    | between tokens, delimiters ignored
// DIGIT   | accumulating a token (signed build: may hold just a '-')
// DISCARD | malformed token, waiting for a delimiter
// DONE    | buffer full, bytes ignored until start or reset
// ---------------------------------------------------------------------------
module rx_dec_loader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    input  logic              start,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sat
);

    localparam int ACC_W = DATA_W + 5;
    localparam logic [ACC_W-1:0] TEN  = ACC_W'(10);
    localparam logic [AW:0]      LAST = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        SKIP    = 2'd0,
        DIGIT   = 2'd1,
        DISCARD = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic               have_digit;
    logic               tok_sat;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               is_digit;
    logic               is_delim;
    logic [ACC_W-1:0]   limit;
    logic [ACC_W-1:0]   step_base;
    logic [ACC_W-1:0]   step_raw;
    logic [ACC_W-1:0]   step_val;
    logic               step_ovf;
    logic [DATA_W-1:0]  wr_val;
    logic               commit;

    assign is_digit = (data_in >= 8'h30) && (data_in <= 8'h39);
    assign is_delim = (data_in == 8'h20) || (data_in == 8'h2C) ||
                      (data_in == 8'h0D) || (data_in == 8'h0A);

`ifdef RX_DEC_LOADER_SIGNED_EN
    localparam logic [ACC_W-1:0] POS_MAX = {6'd0, {(DATA_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] NEG_MAX = {5'd0, 1'b1, {(DATA_W-1){1'b0}}};

    logic neg;
    logic is_minus;

    assign is_minus = (data_in == 8'h2D);
    // A digit seen in SKIP always begins a positive token, whatever the
    // sign of the previous one.
    assign limit    = (state == DIGIT && neg) ? NEG_MAX : POS_MAX;
    assign wr_val   = neg ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
`else
    localparam logic [ACC_W-1:0] UMAX = {5'd0, {DATA_W{1'b1}}};

    assign limit  = UMAX;
    assign wr_val = acc[DATA_W-1:0];
`endif

    // Accumulator is clamped after every digit, so acc*10+9 never overflows
    // ACC_W and the comparison against the limit stays exact however many
    // digits arrive.
    assign step_base = (state == DIGIT) ? acc : '0;
    assign step_raw  = step_base * TEN + {{(ACC_W-4){1'b0}}, data_in[3:0]};
    assign step_ovf  = (step_raw > limit);
    assign step_val  = step_ovf ? limit : step_raw;

    assign commit = !start && data_valid && (state == DIGIT) &&
                    is_delim && have_digit;

    assign busy = (state == DIGIT) || (state == DISCARD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SKIP;
            acc        <= '0;
            have_digit <= 1'b0;
            tok_sat    <= 1'b0;
            count      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            sat        <= 1'b0;
`ifdef RX_DEC_LOADER_SIGNED_EN
            neg        <= 1'b0;
`endif
        end else if (start) begin
            state      <= SKIP;
            acc        <= '0;
            have_digit <= 1'b0;
            tok_sat    <= 1'b0;
            count      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            sat        <= 1'b0;
`ifdef RX_DEC_LOADER_SIGNED_EN
            neg        <= 1'b0;
`endif
        end else if (data_valid) begin
            case (state)
                SKIP: begin
                    if (is_digit) begin
                        acc        <= step_val;
                        tok_sat    <= step_ovf;
                        have_digit <= 1'b1;
`ifdef RX_DEC_LOADER_SIGNED_EN
                        neg        <= 1'b0;
`endif
                        state      <= DIGIT;
`ifdef RX_DEC_LOADER_SIGNED_EN
                    end else if (is_minus) begin
                        acc        <= '0;
                        tok_sat    <= 1'b0;
                        have_digit <= 1'b0;
                        neg        <= 1'b1;
                        state      <= DIGIT;
`endif
                    end else if (!is_delim) begin
                        err   <= 1'b1;
                        state <= DISCARD;
                    end
                end

                DIGIT: begin
                    if (is_digit) begin
                        acc        <= step_val;
                        tok_sat    <= tok_sat | step_ovf;
                        have_digit <= 1'b1;
                    end else if (is_delim) begin
                        if (have_digit) begin
                            count <= count + 1'b1;
                            sat   <= sat | tok_sat;
                            if (count == LAST) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                state <= SKIP;
                            end
                        end else begin
                            // lone '-' terminated by a delimiter
                            err   <= 1'b1;
                            state <= SKIP;
                        end
                    end else begin
                        err   <= 1'b1;
                        state <= DISCARD;
                    end
                end

                DISCARD: begin
                    if (is_delim) begin
                        state <= SKIP;
                    end
                end

                DONE: begin
                    state <= DONE;
                end

                default: begin
                    state <= SKIP;
                end
            endcase
        end
    end

    // Buffer has no reset: contents survive both reset and start.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[count[AW-1:0]] <= wr_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
